// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock
// on sout with a framing strobe, a done pulse after each word and an optional idle gap.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam bit NO_GAP = (GAP == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_next;
  logic [GW-1:0]    r_gapcnt;
  logic [GW-1:0]    w_gapcnt_next;
  logic             r_done;

  logic             w_head;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_accept;

  // The head bit is the one on the wire; shifting moves the next bit into it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_head    = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_head    = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_last    = (r_state == S_SHIFT) && (r_bitcnt == '0);
  assign din_ready = (r_state == S_IDLE) || (w_last && NO_GAP);
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_gapcnt_next = r_gapcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next  = S_SHIFT;
          w_shift_next  = din;
          w_bitcnt_next = CW'(WIDTH - 1);
        end
      end
      S_SHIFT: begin
        if (r_bitcnt != '0) begin
          w_shift_next  = w_shifted;
          w_bitcnt_next = r_bitcnt - CW'(1);
        end else if (!NO_GAP) begin
          w_state_next  = S_GAP;
          w_shift_next  = w_shifted;
          w_gapcnt_next = GW'(GAP);
        end else if (w_accept) begin
          // Back-to-back: the next word's first bit follows the last bit directly.
          w_shift_next  = din;
          w_bitcnt_next = CW'(WIDTH - 1);
        end else begin
          w_state_next  = S_IDLE;
          w_shift_next  = w_shifted;
        end
      end
      S_GAP: begin
        if (r_gapcnt <= GW'(1)) begin
          w_state_next  = S_IDLE;
          w_gapcnt_next = '0;
        end else begin
          w_gapcnt_next = r_gapcnt - GW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bitcnt <= w_bitcnt_next;
      r_gapcnt <= w_gapcnt_next;
      r_done   <= w_last;
    end
  end

  assign sframe = (r_state == S_SHIFT);
  assign sout   = sframe && w_head;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: six parameter sets run side by side, each checked every
// cycle against a timeline model built from accept times and the word bits.
`timescale 1ns/1ps
module tb_piso_shift_tx;
  localparam int W     = 4;
  localparam int NCFG  = 6;
  localparam int NSLOT = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int GAP_I = (gi / 2 == 0) ? 0 : ((gi / 2 == 1) ? 1 : 3);
    localparam bit MSB_I = (gi % 2 == 0);

    logic         rst_g;
    logic         v_g;
    logic [W-1:0] d_g;
    logic         ready_w, sout_w, sframe_w, busy_w, done_w;
    bit           fin = 1'b0;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(MSB_I), .GAP(GAP_I)) u_dut (
      .clk       (clk),
      .rst       (rst_g),
      .din       (d_g),
      .din_valid (v_g),
      .din_ready (ready_w),
      .sout      (sout_w),
      .sframe    (sframe_w),
      .busy      (busy_w),
      .done      (done_w)
    );

    // Expected per-cycle values, indexed by cycle number modulo NSLOT.
    bit exp_frame [NSLOT];
    bit exp_sout  [NSLOT];
    bit exp_done  [NSLOT];
    int cyc;
    int free_cycle;
    int last_busy;

    function automatic void model_reset();
      for (int i = 0; i < NSLOT; i++) begin
        exp_frame[i] = 1'b0;
        exp_sout[i]  = 1'b0;
        exp_done[i]  = 1'b0;
      end
      free_cycle = cyc;
      last_busy  = cyc - 1;
    endfunction

    // Word accepted on edge k: bits in cycles k+1..k+W, done in k+W+1.
    function automatic void schedule(input int k, input logic [W-1:0] word);
      for (int i = 1; i <= W; i++) begin
        exp_frame[(k + i) % NSLOT] = 1'b1;
        exp_sout[(k + i) % NSLOT]  = MSB_I ? word[W-i] : word[i-1];
      end
      exp_done[(k + W + 1) % NSLOT] = 1'b1;
      last_busy  = k + W + GAP_I;
      free_cycle = k + W + GAP_I + ((GAP_I > 0) ? 1 : 0);
    endfunction

    task automatic check_cycle();
      int s;
      s = cyc % NSLOT;
      check($sformatf("cfg%0d sout c%0d", gi, cyc), int'(sout_w), int'(exp_sout[s]));
      check($sformatf("cfg%0d sframe c%0d", gi, cyc), int'(sframe_w), int'(exp_frame[s]));
      check($sformatf("cfg%0d done c%0d", gi, cyc), int'(done_w), int'(exp_done[s]));
      check($sformatf("cfg%0d busy c%0d", gi, cyc), int'(busy_w), int'(cyc <= last_busy));
      check($sformatf("cfg%0d din_ready c%0d", gi, cyc), int'(ready_w), int'(cyc >= free_cycle));
    endtask

    // Called at a falling edge: drive inputs, pass one rising edge, check the new cycle.
    task automatic tick(input logic v, input logic [W-1:0] d, output logic acc);
      int s;
      v_g = v;
      d_g = d;
      @(posedge clk);
      acc = v && !rst_g && (cyc >= free_cycle);
      if (acc) schedule(cyc, d);
      s = cyc % NSLOT;
      exp_frame[s] = 1'b0;
      exp_sout[s]  = 1'b0;
      exp_done[s]  = 1'b0;
      cyc++;
      @(negedge clk);
      check_cycle();
    endtask

    task automatic send(input logic [W-1:0] word);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 32) begin
        tick(1'b1, word, acc);
        tries++;
      end
      if (!acc) check($sformatf("cfg%0d accept timeout %0h", gi, word), int'(acc), 1);
    endtask

    task automatic idle(input int n);
      logic acc;
      repeat (n) tick(1'b0, W'($urandom), acc);
    endtask

    initial begin : run
      logic acc;
      rst_g = 1'b1;
      v_g   = 1'b0;
      d_g   = '0;
      cyc   = 0;
      model_reset();
      @(negedge clk);
      tick(1'b1, 4'hF, acc);
      tick(1'b1, 4'hA, acc);
      rst_g = 1'b0;
      idle(1);

      send(4'b1011);  idle(W + GAP_I + 2);
      send(4'b0001);  idle(W + GAP_I + 2);
      send(4'b1100);  send(4'b0011);  idle(W + GAP_I + 2);
      send(4'b0101);  send(4'b1111);  idle(W + GAP_I + 2);

      // Asynchronous reset between edges, after the second bit is on the wire.
      send(4'b1010);
      tick(1'b0, 4'h0, acc);
      #2;
      rst_g = 1'b1;
      #1;
      model_reset();
      check_cycle();
      tick(1'b1, 4'h9, acc);
      rst_g = 1'b0;
      idle(1);
      send(4'b0110);  idle(W + GAP_I + 2);

      for (int w = 0; w < 16; w++) begin
        send(W'(w));
        idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 60; i++) tick(1'($urandom_range(0, 1)), W'($urandom), acc);
      for (int i = 0; i < 25; i++) tick(1'b1, W'($urandom), acc);
      idle(W + GAP_I + 3);
      fin = 1'b1;
    end
  end

  wire all_fin = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin &
                 g_cfg[3].fin & g_cfg[4].fin & g_cfg[5].fin;

  initial begin : main
    int guard;
    guard = 0;
    while (!all_fin && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (!all_fin) check("run timeout", int'(all_fin), 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
